// File: rtl/arb_pkg.sv
// Shared types and sizing for the eight-client request arbiter.
package arb_pkg;

  localparam int ARB_N   = 8;
  localparam int ARB_IDW = 3;
  localparam int HOLD_W  = 8;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  function automatic logic [ARB_N-1:0] arb_onehot(input logic [ARB_IDW-1:0] idx);
    return ARB_N'(1) << idx;
  endfunction

endpackage

// File: rtl/arb_rot_pick.sv
// Rotating priority pick: the bit just below i_ptr has top priority, i_ptr itself the lowest.
module arb_rot_pick
  import arb_pkg::*;
(
  input  logic [ARB_N-1:0]   i_vec,
  input  logic [ARB_IDW-1:0] i_ptr,
  output logic [ARB_IDW-1:0] o_idx,
  output logic               o_any
);

  logic [ARB_N-1:0]   w_rot;
  logic [ARB_IDW-1:0] w_hi;
  logic [ARB_IDW-1:0] w_src;

  always_comb begin
    w_rot = '0;
    w_hi  = '0;
    w_src = '0;
    // Rotated bit k maps to original bit (k + ptr) mod 8, so rotated bit 7 is ptr-1.
    for (int k = 0; k < ARB_N; k++) begin
      w_src    = ARB_IDW'(k) + i_ptr;
      w_rot[k] = i_vec[w_src];
    end
    for (int k = 0; k < ARB_N; k++) begin
      if (w_rot[k]) w_hi = ARB_IDW'(k);
    end
    o_idx = w_hi + i_ptr;
    o_any = |i_vec;
  end

endmodule

// File: rtl/req_arbiter8.sv
// Eight-client arbiter with fixed or round-robin priority, registered one-hot grant and hold timeout.
module req_arbiter8
  import arb_pkg::*;
#(
  parameter int RR       = 1,
  parameter int MAX_HOLD = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [ARB_N-1:0]   req,
  output logic [ARB_N-1:0]   gnt,
  output logic [ARB_IDW-1:0] gnt_id,
  output logic               gnt_valid,
  output logic               timeout,
  output arb_state_e         o_dbg_state
);

  // Handshake: a client raises req[i] and keeps it high for the whole transaction;
  // gnt[i] appears one edge later and stays until req[i] is sampled low or the hold
  // limit is hit. Every grant is followed by at least one idle cycle.

  localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD);
  localparam bit                HOLD_EN    = (MAX_HOLD != 0);

  arb_state_e         r_state;
  logic [ARB_N-1:0]   r_gnt;
  logic [ARB_N-1:0]   r_block;
  logic [ARB_IDW-1:0] r_id;
  logic [ARB_IDW-1:0] r_ptr;
  logic [HOLD_W-1:0]  r_cnt;
  logic               r_valid;
  logic               r_timeout;

  logic [ARB_N-1:0]   w_elig;
  logic [ARB_IDW-1:0] w_pick_ptr;
  logic [ARB_IDW-1:0] w_win;
  logic               w_any;
  logic               w_req_held;
  logic               w_hold_expired;

  assign w_elig         = req & ~r_block;
  assign w_pick_ptr     = (RR != 0) ? r_ptr : '0;
  assign w_req_held     = req[r_id];
  assign w_hold_expired = HOLD_EN && (r_cnt >= HOLD_LIMIT);

  arb_rot_pick u_pick (
    .i_vec (w_elig),
    .i_ptr (w_pick_ptr),
    .o_idx (w_win),
    .o_any (w_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ARB_IDLE;
      r_gnt     <= '0;
      r_block   <= '0;
      r_id      <= '0;
      r_ptr     <= '0;
      r_cnt     <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      r_block   <= r_block & req;
      case (r_state)
        ARB_IDLE: begin
          if (en && w_any) begin
            r_state <= ARB_GRANT;
            r_gnt   <= arb_onehot(w_win);
            r_id    <= w_win;
            r_valid <= 1'b1;
            r_cnt   <= HOLD_W'(1);
            r_ptr   <= w_win;
          end
        end
        ARB_GRANT: begin
          // Release wins over timeout when both land on the same edge.
          if (!w_req_held) begin
            r_state <= ARB_IDLE;
            r_gnt   <= '0;
            r_id    <= '0;
            r_valid <= 1'b0;
            r_cnt   <= '0;
          end else if (w_hold_expired) begin
            r_state   <= ARB_IDLE;
            r_gnt     <= '0;
            r_id      <= '0;
            r_valid   <= 1'b0;
            r_cnt     <= '0;
            r_timeout <= 1'b1;
            r_block   <= (r_block & req) | r_gnt;
          end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + HOLD_W'(1);
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  assign gnt         = r_gnt;
  assign gnt_id      = r_id;
  assign gnt_valid   = r_valid;
  assign timeout     = r_timeout;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_req_arbiter8.sv
// Bench for req_arbiter8: three configurations share one directed stimulus and a per-instance reference model.
module tb_req_arbiter8;
  import arb_pkg::*;

  // ---------------- clock / reset ----------------
  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] req;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: fixed, hold 16. Instance 1: round-robin, hold 4. Instance 2: fixed, hold 3.
  logic [2:0][7:0] gnt_w;
  logic [2:0][2:0] id_w;
  logic [2:0]      val_w;
  logic [2:0]      to_w;
  arb_state_e      st_w [3];

  req_arbiter8 #(.RR(0), .MAX_HOLD(16)) u_fix (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req), .gnt(gnt_w[0]), .gnt_id(id_w[0]),
    .gnt_valid(val_w[0]), .timeout(to_w[0]), .o_dbg_state(st_w[0]));
  req_arbiter8 #(.RR(1), .MAX_HOLD(4)) u_rr (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req), .gnt(gnt_w[1]), .gnt_id(id_w[1]),
    .gnt_valid(val_w[1]), .timeout(to_w[1]), .o_dbg_state(st_w[1]));
  req_arbiter8 #(.RR(0), .MAX_HOLD(3)) u_to3 (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req), .gnt(gnt_w[2]), .gnt_id(id_w[2]),
    .gnt_valid(val_w[2]), .timeout(to_w[2]), .o_dbg_state(st_w[2]));

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [inst %0d] t=%0t: got 0x%0h, expected 0x%0h", name, k, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int         rr_p [3] = '{0, 1, 0};
  int         mh_p [3] = '{16, 4, 3};
  bit         m_busy [3] = '{0, 0, 0};
  bit         m_to   [3] = '{0, 0, 0};
  int         m_owner[3] = '{0, 0, 0};
  int         m_held [3] = '{0, 0, 0};
  int         m_ptr  [3] = '{0, 0, 0};
  logic [7:0] m_blk  [3] = '{8'h00, 8'h00, 8'h00};

  task automatic model_step(input int k);
    logic [7:0] elig;
    logic [7:0] setb;
    bit         tnow;
    int         w;
    int         c;
    elig = req & ~m_blk[k];
    setb = 8'h00;
    tnow = 1'b0;
    if (m_busy[k]) begin
      if (!req[m_owner[k]]) begin
        m_busy[k] = 1'b0;
      end else if (mh_p[k] != 0 && m_held[k] >= mh_p[k]) begin
        m_busy[k] = 1'b0;
        tnow = 1'b1;
        setb[m_owner[k]] = 1'b1;
      end else if (m_held[k] < 255) begin
        m_held[k]++;
      end
    end else if (en) begin
      w = -1;
      for (int s = 1; s <= 8; s++) begin
        c = (m_ptr[k] - s + 8) % 8;
        if (w < 0 && elig[c]) w = c;
      end
      if (w >= 0) begin
        m_busy[k]  = 1'b1;
        m_owner[k] = w;
        m_held[k]  = 1;
        if (rr_p[k] != 0) m_ptr[k] = w;
      end
    end
    m_blk[k] = (m_blk[k] & req) | setb;
    m_to[k]  = tnow;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        m_busy[k] = 1'b0; m_to[k] = 1'b0; m_owner[k] = 0;
        m_held[k] = 0;    m_ptr[k] = 0;   m_blk[k] = 8'h00;
      end
    end else begin
      for (int k = 0; k < 3; k++) model_step(k);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      logic [7:0] eg;
      eg = m_busy[k] ? (8'd1 << m_owner[k]) : 8'd0;
      check("gnt", k, 32'(gnt_w[k]), 32'(eg));
      check("gnt_id", k, 32'(id_w[k]), m_busy[k] ? 32'(m_owner[k]) : 32'd0);
      check("gnt_valid", k, 32'(val_w[k]), 32'(m_busy[k]));
      check("timeout", k, 32'(to_w[k]), 32'(m_to[k]));
      check("state", k, 32'(st_w[k] == ARB_GRANT), 32'(m_busy[k]));
      check("onehot0", k, 32'($onehot0(gnt_w[k])), 32'd1);
      check("valid_eq_or", k, 32'(val_w[k]), 32'(|gnt_w[k]));
    end
  end

  // ---------------- driver / directed stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; req = 8'h00;
    cyc(2);
    for (int k = 0; k < 3; k++) begin
      check("rst_gnt", k, 32'(gnt_w[k]), 32'h0);
      check("rst_valid", k, 32'(val_w[k]), 32'h0);
      check("rst_timeout", k, 32'(to_w[k]), 32'h0);
    end
    rst_n = 1'b1;

    // Fixed priority
    en = 1'b1; req = 8'b0010_0110;
    cyc(1);
    check("fix_gnt", 0, 32'(gnt_w[0]), 32'h20);
    check("fix_id", 0, 32'(id_w[0]), 32'd5);
    req = 8'b0000_0110;
    cyc(1);
    check("fix_bubble", 0, 32'(gnt_w[0]), 32'h00);
    cyc(1);
    check("fix_id2", 0, 32'(id_w[0]), 32'd2);
    check("fix_gnt2", 0, 32'(gnt_w[0]), 32'h04);
    req = 8'h00;
    cyc(2);

    // Round-robin from a fresh pointer
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    req = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      int e;
      e = 7 - (i % 8);
      cyc(1);
      check("rr_id", 1, 32'(id_w[1]), 32'(e));
      check("rr_valid", 1, 32'(val_w[1]), 32'd1);
      cyc(1);
      req[e] = 1'b0;
      cyc(1);
      check("rr_bubble", 1, 32'(val_w[1]), 32'd0);
      req[e] = 1'b1;
    end
    req = 8'h00;
    cyc(2);

    // Timeout with hold 4 on the round-robin instance
    req = 8'h01;
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      check("to_hold", 1, 32'(val_w[1]), 32'd1);
      check("to_quiet", 1, 32'(to_w[1]), 32'd0);
    end
    cyc(1);
    check("to_pulse", 1, 32'(to_w[1]), 32'd1);
    check("to_revoked", 1, 32'(val_w[1]), 32'd0);
    cyc(1);
    check("to_pulse_end", 1, 32'(to_w[1]), 32'd0);
    check("to_blocked", 1, 32'(val_w[1]), 32'd0);
    cyc(1);
    check("to_blocked2", 1, 32'(val_w[1]), 32'd0);
    req = 8'h00;
    cyc(1);
    req = 8'h01;
    cyc(1);
    check("to_regrant", 1, 32'(gnt_w[1]), 32'h01);
    req = 8'h00;
    cyc(2);

    // Enable gating
    en = 1'b0; req = 8'h80;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      check("en_block", 0, 32'(val_w[0]), 32'd0);
    end
    en = 1'b1;
    cyc(1);
    check("en_grant", 0, 32'(gnt_w[0]), 32'h80);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      check("en_persist", 0, 32'(gnt_w[0]), 32'h80);
    end
    req = 8'h00;
    cyc(1);
    check("en_release", 0, 32'(val_w[0]), 32'd0);
    en = 1'b1;
    cyc(1);

    // Reset mid-grant
    req = 8'h10;
    cyc(1);
    check("rm_gnt", 0, 32'(gnt_w[0]), 32'h10);
    check("rm_rr_id", 1, 32'(id_w[1]), 32'd4);
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check("rm_async_gnt", k, 32'(gnt_w[k]), 32'h0);
      check("rm_async_id", k, 32'(id_w[k]), 32'h0);
      check("rm_async_valid", k, 32'(val_w[k]), 32'h0);
      check("rm_async_to", k, 32'(to_w[k]), 32'h0);
    end
    req = 8'h18;
    #1 rst_n = 1'b1;
    cyc(1);
    check("rm_ptr0_id", 1, 32'(id_w[1]), 32'd4);
    check("rm_fix_id", 0, 32'(id_w[0]), 32'd4);
    req = 8'h00;
    cyc(2);

    // Release on the same edge the hold limit is hit (hold 3 instance)
    req = 8'h04;
    cyc(1);
    check("sim_grant", 2, 32'(val_w[2]), 32'd1);
    cyc(2);
    check("sim_held3", 2, 32'(val_w[2]), 32'd1);
    req = 8'h00;
    cyc(1);
    check("sim_no_to", 2, 32'(to_w[2]), 32'd0);
    check("sim_release", 2, 32'(val_w[2]), 32'd0);
    req = 8'h04;
    cyc(1);
    check("sim_regrant", 2, 32'(gnt_w[2]), 32'h04);
    req = 8'h00;
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
